// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- built-in self-test initiator for a single-port synchronous RAM.
//
// Walks START_ADDR..END_ADDR in steps of STRIDE. It writes the pattern
// (addr - PAT_OFFSET) mod 2^DATA_W, then reads the same walk back. Each read
// is compared one cycle later, against an expectation held in a 1-stage
// pipeline. This matches the RAM's 1-cycle read latency.
//
// Optional feature macro: RAM_BIST_INV_PASS_EN
//   Adds a second WRITE/READ/DRAIN pass with the inverted pattern. Errors
//   accumulate across both passes.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a test (sampled only while idle)
//   busy                high from the cycle after start through the done cycle
//   done                one-cycle end-of-test pulse
//   pass                test result, valid from done until the next start
//   err_count           saturating mismatch count
//   fail_addr/fail_data address and read data of the first mismatch
//   mem_we/mem_addr/mem_data_in  RAM write/address side
//   mem_data_out        RAM read data (1-cycle latency)
module ram_bist_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 1,
  parameter int END_ADDR   = 23,
  parameter int STRIDE     = 2,
  parameter int PAT_OFFSET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] START_A  = ADDR_W'(START_ADDR);
  // End and stride are kept one bit wider so the last-address test cannot wrap.
  localparam logic [ADDR_W:0]   END_W    = (ADDR_W+1)'(END_ADDR);
  localparam logic [ADDR_W:0]   STRIDE_W = (ADDR_W+1)'(STRIDE);
  localparam bit                EMPTY    = (END_ADDR < START_ADDR);

  // Address-derived data pattern. The subtraction is widened so that the
  // modulo-2^DATA_W result is correct for any ADDR_W/DATA_W relation.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    return DATA_W'((ADDR_W+DATA_W)'(a) - (ADDR_W+DATA_W)'(PAT_OFFSET));
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [7:0]          err_q, err_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic [DATA_W-1:0]   exp_data_q, exp_data_d;
  logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic                inv_q, inv_d;

  logic [ADDR_W:0]     nxt_w_s;
  logic                last_s;
  logic                mismatch_s;
  logic [DATA_W-1:0]   mask_s;

  // Next walk address and the "this is the final address" decision.
  always_comb begin
    nxt_w_s = {1'b0, addr_q} + STRIDE_W;
    last_s  = (nxt_w_s > END_W);
    mask_s  = {DATA_W{inv_q}};
  end

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    exp_data_d  = exp_data_q;
    exp_addr_d  = exp_addr_q;
    cmp_vld_d   = 1'b0;
    inv_d       = inv_q;

    // The data on mem_data_out belongs to the address registered last cycle.
    mismatch_s = cmp_vld_q && (mem_data_out != exp_data_q);
    if (mismatch_s) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end else begin
        err_d = err_q;
      end
      // Only the first mismatch of a test is recorded.
      if (err_q == 8'd0) begin
        fail_addr_d = exp_addr_q;
        fail_data_d = mem_data_out;
      end else begin
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
      end
    end else begin
      err_d = err_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_d       = 8'd0;
          fail_addr_d = '0;
          fail_data_d = '0;
          inv_d       = 1'b0;
          addr_d      = START_A;
          if (EMPTY) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            wdata_d = pattern(START_A);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (last_s) begin
          state_d = S_READ;
          addr_d  = START_A;
          wdata_d = '0;
        end else begin
          addr_d  = nxt_w_s[ADDR_W-1:0];
          we_d    = 1'b1;
          wdata_d = pattern(nxt_w_s[ADDR_W-1:0]) ^ mask_s;
        end
      end
      S_READ: begin
        cmp_vld_d  = 1'b1;
        exp_data_d = pattern(addr_q) ^ mask_s;
        exp_addr_d = addr_q;
        if (last_s) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = nxt_w_s[ADDR_W-1:0];
        end
      end
      S_DRAIN: begin
`ifdef RAM_BIST_INV_PASS_EN
        if (!inv_q) begin
          state_d = S_WRITE;
          inv_d   = 1'b1;
          addr_d  = START_A;
          we_d    = 1'b1;
          wdata_d = ~pattern(START_A);
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end
`else
        state_d = S_DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == 8'd0);
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      exp_data_q  <= '0;
      exp_addr_q  <= '0;
      cmp_vld_q   <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      exp_data_q  <= exp_data_d;
      exp_addr_q  <= exp_addr_d;
      cmp_vld_q   <= cmp_vld_d;
      inv_q       <= inv_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: a behavioural RAM with injectable
// stuck-at-1 faults on bit 0, plus a second instance configured with an
// empty address range.
module tb_ram_bist_ctrl;

  localparam int N = 12;
`ifdef RAM_BIST_INV_PASS_EN
  localparam int EXP_DONE = 51;
`else
  localparam int EXP_DONE = 26;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [19:0] fail_addr;
  logic [7:0]  fail_data;
  logic        mem_we;
  logic [19:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;

  logic        start_e;
  logic        e_busy, e_done, e_pass;
  logic [7:0]  e_err_count;
  logic [19:0] e_fail_addr;
  logic [7:0]  e_fail_data;
  logic        e_mem_we;
  logic [19:0] e_mem_addr;
  logic [7:0]  e_mem_data_in;
  logic        e_we_seen = 1'b0;

  logic        flt_en0, flt_en1;
  logic [19:0] flt_a0, flt_a1;
  logic [7:0]  ram [0:1048575];

  int total = 0;
  int bad   = 0;
  int done_at;
  logic       pass_c1;
  logic [7:0] err_c1;

  ram_bist_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  ram_bist_ctrl #(.START_ADDR(1), .END_ADDR(0)) u_empty (
    .clk(clk), .rst(rst), .start(start_e),
    .busy(e_busy), .done(e_done), .pass(e_pass),
    .err_count(e_err_count), .fail_addr(e_fail_addr), .fail_data(e_fail_data),
    .mem_we(e_mem_we), .mem_addr(e_mem_addr), .mem_data_in(e_mem_data_in),
    .mem_data_out(8'h00)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM with 1-cycle read latency; faulty addresses read with bit 0 forced to 1.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_data_in;
    mem_data_out <= ram[mem_addr] |
      (((flt_en0 && mem_addr == flt_a0) || (flt_en1 && mem_addr == flt_a1)) ? 8'h01 : 8'h00);
  end

  // Sticky record of any write from the empty-range instance.
  always @(posedge clk) begin
    if (e_mem_we) e_we_seen <= 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected RAM port activity for cycle c after the start edge.
  task automatic walk_check(input int c);
    if (c <= N) begin
      check_eq($sformatf("wr_we@%0d", c), 32'(mem_we), 32'd1);
      check_eq($sformatf("wr_addr@%0d", c), 32'(mem_addr), 32'(1 + 2 * (c - 1)));
      check_eq($sformatf("wr_data@%0d", c), 32'(mem_data_in), 32'(2 * (c - 1)));
    end else if (c <= 2 * N) begin
      check_eq($sformatf("rd_we@%0d", c), 32'(mem_we), 32'd0);
      check_eq($sformatf("rd_addr@%0d", c), 32'(mem_addr), 32'(1 + 2 * (c - N - 1)));
`ifdef RAM_BIST_INV_PASS_EN
    end else if (c >= 2 * N + 2 && c <= 3 * N + 1) begin
      check_eq($sformatf("wr2_we@%0d", c), 32'(mem_we), 32'd1);
      check_eq($sformatf("wr2_addr@%0d", c), 32'(mem_addr), 32'(1 + 2 * (c - 2 * N - 2)));
      check_eq($sformatf("wr2_data@%0d", c), 32'(mem_data_in), 32'(255 - 2 * (c - 2 * N - 2)));
    end else if (c >= 3 * N + 2 && c <= 4 * N + 1) begin
      check_eq($sformatf("rd2_we@%0d", c), 32'(mem_we), 32'd0);
      check_eq($sformatf("rd2_addr@%0d", c), 32'(mem_addr), 32'(1 + 2 * (c - 3 * N - 2)));
`endif
    end else begin
      check_eq($sformatf("idle_we@%0d", c), 32'(mem_we), 32'd0);
    end
  endtask

  // Pulse (or hold) start and follow the run to its done pulse.
  task automatic run_bist(input bit hold_start, input bit check_walk, output int d_at);
    int busy_low;
    busy_low = 0;
    d_at = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      if (c == 1) begin
        pass_c1 = pass;
        err_c1  = err_count;
      end
      if (check_walk) walk_check(c);
      if (!busy) busy_low++;
      if (done) begin
        d_at = c;
        break;
      end
    end
    start = 1'b0;
    check_eq("busy_during_run", 32'(busy_low), 32'd0);
    @(negedge clk);
    check_eq("busy_after_done", 32'(busy), 32'd0);
    check_eq("done_pulse_len", 32'(done), 32'd0);
  endtask

  initial begin
    int n_done;
    rst = 1'b1;
    start = 1'b0;
    start_e = 1'b0;
    flt_en0 = 1'b0;
    flt_en1 = 1'b0;
    flt_a0 = 20'd0;
    flt_a1 = 20'd0;
    repeat (2) @(negedge clk);

    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_data_in), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_err", 32'(err_count), 32'd0);
    check_eq("rst_fail_addr", 32'(fail_addr), 32'd0);
    check_eq("rst_fail_data", 32'(fail_data), 32'd0);
    rst = 1'b0;

    // Clean RAM, full walk checked cycle by cycle.
    run_bist(1'b0, 1'b1, done_at);
    check_eq("clean_done_cycle", 32'(done_at), 32'(EXP_DONE));
    check_eq("clean_pass", 32'(pass), 32'd1);
    check_eq("clean_err", 32'(err_count), 32'd0);

    // Bit 0 stuck-at-1 at address 7.
    flt_en0 = 1'b1;
    flt_a0 = 20'd7;
    run_bist(1'b0, 1'b0, done_at);
    check_eq("f7_done_cycle", 32'(done_at), 32'(EXP_DONE));
    check_eq("f7_pass", 32'(pass), 32'd0);
    check_eq("f7_err", 32'(err_count), 32'd1);
    check_eq("f7_fail_addr", 32'(fail_addr), 32'd7);
    check_eq("f7_fail_data", 32'(fail_data), 32'd7);

    // Faults at 5 and 15: first one retained.
    flt_a0 = 20'd5;
    flt_en1 = 1'b1;
    flt_a1 = 20'd15;
    run_bist(1'b0, 1'b0, done_at);
    check_eq("f2_pass", 32'(pass), 32'd0);
    check_eq("f2_err", 32'(err_count), 32'd2);
    check_eq("f2_fail_addr", 32'(fail_addr), 32'd5);
    check_eq("f2_fail_data", 32'(fail_data), 32'd5);

    // Start held high for the whole run: no restart, results cleared by start.
    flt_en0 = 1'b0;
    flt_en1 = 1'b0;
    run_bist(1'b1, 1'b0, done_at);
    check_eq("hold_clear_pass", 32'(pass_c1), 32'd0);
    check_eq("hold_clear_err", 32'(err_c1), 32'd0);
    check_eq("hold_done_cycle", 32'(done_at), 32'(EXP_DONE));
    check_eq("hold_pass", 32'(pass), 32'd1);

    // Empty range: done the cycle after start, no RAM access.
    @(negedge clk);
    start_e = 1'b1;
    @(negedge clk);
    start_e = 1'b0;
    check_eq("empty_done_c1", 32'(e_done), 32'd1);
    check_eq("empty_busy_c1", 32'(e_busy), 32'd1);
    check_eq("empty_pass", 32'(e_pass), 32'd1);
    @(negedge clk);
    check_eq("empty_done_c2", 32'(e_done), 32'd0);
    check_eq("empty_busy_c2", 32'(e_busy), 32'd0);

    // Reset asserted during the 4th write cycle.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_we", 32'(mem_we), 32'd1);
    check_eq("pre_rst_addr", 32'(mem_addr), 32'd7);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_we", 32'(mem_we), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) n_done++;
    end
    check_eq("post_rst_quiet", 32'(n_done), 32'd0);
    run_bist(1'b0, 1'b0, done_at);
    check_eq("post_rst_done_cycle", 32'(done_at), 32'(EXP_DONE));
    check_eq("post_rst_pass", 32'(pass), 32'd1);
    check_eq("post_rst_err", 32'(err_count), 32'd0);

    check_eq("empty_never_wrote", 32'(e_we_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
